// File: rtl/jtexterm_palwr.sv
// Palette write buffer: CPU byte writes queue in a FIFO and are replayed
// onto the palette RAM write port only while the screen is blanked.
module jtexterm_palwr #(
  parameter int AW       = 4,
  parameter bit DRAIN_HB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  input  logic       cpu_rnw,
  input  logic       pal_cs,
  output logic       cpu_wait,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       fifo_empty
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } state_t;

  state_t        r_state;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [17:0]   r_mem [DEPTH];
  logic          r_wr_req_d;
  logic          r_pend;
  logic [9:0]    r_pend_addr;
  logic [7:0]    r_pend_data;
  logic          r_we;
  logic [9:0]    r_addr;
  logic [7:0]    r_data;

  logic        w_wr_req;
  logic        w_rise;
  logic        w_full;
  logic        w_empty;
  logic        w_blank;
  logic        w_pop;
  logic        w_room;
  logic        w_push;
  logic [17:0] w_push_ent;
  logic [17:0] w_head;

  assign w_wr_req = pal_cs & ~cpu_rnw;
  assign w_rise   = w_wr_req & ~r_wr_req_d;
  assign w_full   = r_cnt == (AW+1)'(DEPTH);
  assign w_empty  = r_cnt == '0;
  assign w_blank  = ~LVBL | (DRAIN_HB & ~LHBL);
  assign w_pop    = w_blank & ~w_empty;
  // A pop on the same edge frees the slot a new write needs.
  assign w_room   = ~w_full | w_pop;
  assign w_push   = r_pend ? w_room : (w_rise & w_room);
  assign w_head   = r_mem[r_rptr];

  always_comb begin
    w_push_ent = {cpu_addr, cpu_dout};
    if (r_pend)
      w_push_ent = {r_pend_addr, r_pend_data};
  end

  assign cpu_wait   = r_pend | (w_rise & ~w_room);
  assign fifo_empty = w_empty;
  assign ram_we     = r_we;
  assign ram_addr   = r_addr;
  assign ram_data   = r_data;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= w_push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_req_d <= 1'b0;
    end else begin
      r_wr_req_d <= w_wr_req;
    end
  end

  // Overflowed write is parked here while the CPU is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (r_pend) begin
      if (w_room)
        r_pend <= 1'b0;
    end else if (w_rise && !w_room) begin
      r_pend      <= 1'b1;
      r_pend_addr <= cpu_addr;
      r_pend_data <= cpu_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_blank && !w_empty)
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!w_blank)
            r_state <= ST_IDLE;
          else if (w_pop && !w_push && r_cnt == (AW+1)'(1))
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_addr <= w_head[17:8];
        r_data <= w_head[7:0];
      end
    end
  end

endmodule
